transit_ctrl: RTL

TRANSIT_CTRL -- requirements
Module: transit_ctrl

---
 rtl/transit_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/transit_ctrl.sv
// rtl/transit_ctrl.sv - transit controller: command/station-ID sequencing FSM with optional obstacle buzzer
//
// Purpose:
//   Accepts GO/STOP command bytes from a UART receiver and station IDs
//   from a barcode reader. It latches the destination, drives in_transit/go
//   toward the motor path and stops when the destination station is seen.
//   Optional macro OBSTACLE_BUZZ_EN compiles in a differential piezo driver.
//   The driver sounds while moving with the proximity sensor blocked.
//
// Ports:
//   clk          in   system clock, all state on posedge
//   rst          in   asynchronous reset, active-high
//   cmd_rdy      in   command byte available (held until cleared)
//   cmd[7:0]     in   [7:6] opcode (00 STOP, 01 GO, else reserved), [5:0] destination
//   ID_vld       in   station ID available (held until cleared)
//   ID[7:0]      in   [7:6] must be 00 for a valid ID, [5:0] station
//   OK2Move      in   proximity sensor clear (low = obstacle)
//   clr_cmd_rdy  out  one-cycle registered pulse consuming cmd
//   clr_ID_vld   out  one-cycle registered pulse consuming ID
//   in_transit   out  registered, high while MOVING
//   go           out  in_transit & OK2Move
//   dest_ID[5:0] out  latched destination
//   buzz, buzz_n out  differential piezo drive (constant 0 without OBSTACLE_BUZZ_EN)

module transit_ctrl #(
  parameter int BUZZ_HALF = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_rdy,
  input  logic [7:0] cmd,
  input  logic       ID_vld,
  input  logic [7:0] ID,
  input  logic       OK2Move,
  output logic       clr_cmd_rdy,
  output logic       clr_ID_vld,
  output logic       in_transit,
  output logic       go,
  output logic [5:0] dest_ID,
  output logic       buzz,
  output logic       buzz_n
);

  // A half-period of zero cycles has no meaningful buzzer behaviour.
  if (BUZZ_HALF < 1) begin : g_bad_buzz_half
    $error("transit_ctrl: BUZZ_HALF must be at least 1");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;

  state_t     state_q, state_d;
  logic [5:0] dest_q, dest_d;
  logic       clr_cmd_q, clr_cmd_d;
  logic       clr_id_q, clr_id_d;
  logic       in_transit_q;

  logic       cmd_evt;
  logic       id_evt;
  logic       id_match;

  // The producers only drop their valid after seeing our clear pulse, so an
  // input still high in the pulse cycle is the same event and is masked.
  assign cmd_evt  = cmd_rdy & ~clr_cmd_q;
  assign id_evt   = ID_vld & ~clr_id_q;
  assign id_match = (ID[7:6] == 2'b00) && (ID[5:0] == dest_q);

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    clr_cmd_d = 1'b0;
    clr_id_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (id_evt) begin
          clr_id_d = 1'b1;
        end
        if (cmd_evt) begin
          clr_cmd_d = 1'b1;
          if (cmd[7:6] == OP_GO) begin
            dest_d  = cmd[5:0];
            state_d = MOVING;
          end
        end
      end

      MOVING: begin
        if (id_evt) begin
          clr_id_d = 1'b1;
          if (id_match) begin
            state_d = IDLE;
          end
        end
        // Evaluated after the ID so a GO/STOP in the same cycle overrides
        // an arrival decision; reserved opcodes leave the ID outcome alone.
        if (cmd_evt) begin
          clr_cmd_d = 1'b1;
          if (cmd[7:6] == OP_STOP) begin
            state_d = IDLE;
          end else if (cmd[7:6] == OP_GO) begin
            dest_d  = cmd[5:0];
            state_d = MOVING;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dest_q       <= 6'd0;
      clr_cmd_q    <= 1'b0;
      clr_id_q     <= 1'b0;
      in_transit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      clr_cmd_q    <= clr_cmd_d;
      clr_id_q     <= clr_id_d;
      in_transit_q <= (state_d == MOVING);
    end
  end

  assign clr_cmd_rdy = clr_cmd_q;
  assign clr_ID_vld  = clr_id_q;
  assign in_transit  = in_transit_q;
  assign dest_ID     = dest_q;
  assign go          = in_transit_q & OK2Move;

`ifdef OBSTACLE_BUZZ_EN
  localparam int CW = $clog2(BUZZ_HALF + 1);

  logic [CW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic          buzz_q, buzz_d;
  logic          buzz_n_q, buzz_n_d;
  logic          blocked;

  assign blocked = in_transit_q & ~OK2Move;

  always_comb begin
    buzz_cnt_d = '0;
    buzz_d     = 1'b0;
    buzz_n_d   = 1'b0;
    if (blocked) begin
      if (buzz_cnt_q == CW'(BUZZ_HALF - 1)) begin
        buzz_cnt_d = '0;
        buzz_d     = ~buzz_q;
      end else begin
        buzz_cnt_d = buzz_cnt_q + 1'b1;
        buzz_d     = buzz_q;
      end
      buzz_n_d = ~buzz_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzz_cnt_q <= '0;
      buzz_q     <= 1'b0;
      buzz_n_q   <= 1'b0;
    end else begin
      buzz_cnt_q <= buzz_cnt_d;
      buzz_q     <= buzz_d;
      buzz_n_q   <= buzz_n_d;
    end
  end

  assign buzz   = buzz_q;
  assign buzz_n = buzz_n_q;
`else
  assign buzz   = 1'b0;
  assign buzz_n = 1'b0;
`endif

endmodule
